// File: rtl/ycbcr2rgb.sv
// Full-range BT.601 YCbCr to RGB converter: four register stages, one pixel per clock,
// with the sync/valid strobes delayed through a matching four-deep shift register.
module ycbcr2rgb #(
  parameter int          PREC = 10,
  parameter logic [10:0] KRCR = 11'h59C,
  parameter logic [10:0] KGCB = 11'h160,
  parameter logic [10:0] KGCR = 11'h2DB,
  parameter logic [10:0] KBCB = 11'h717
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iY,
  input  logic [7:0] iCb,
  input  logic [7:0] iCr,
  input  logic       iHSync,
  input  logic       iVSync,
  input  logic       iLineValid,
  input  logic       iFrameValid,
  output logic [7:0] oR,
  output logic [7:0] oG,
  output logic [7:0] oB,
  output logic       oHSync,
  output logic       oVSync,
  output logic       oLineValid,
  output logic       oFrameValid
);

  localparam int PW = PREC + 11;
  localparam int SW = PREC + 12;

  // Coefficients are positive magnitudes; zero-extend so they multiply as signed values.
  localparam logic signed [PW-1:0] k_rcr = PW'(KRCR);
  localparam logic signed [PW-1:0] k_gcb = PW'(KGCB);
  localparam logic signed [PW-1:0] k_gcr = PW'(KGCR);
  localparam logic signed [PW-1:0] k_bcb = PW'(KBCB);
  localparam logic signed [SW-1:0] rnd   = SW'(2 ** (PREC - 1));

  // Stage 1
  logic        [7:0] y;
  logic signed [8:0] cb;
  logic signed [8:0] cr;
  // Stage 2
  logic signed [PW-1:0] y2;
  logic signed [PW-1:0] pr;
  logic signed [PW-1:0] pgb;
  logic signed [PW-1:0] pgr;
  logic signed [PW-1:0] pb;
  // Stage 3
  logic signed [SW-1:0] sr;
  logic signed [SW-1:0] sg;
  logic signed [SW-1:0] sb;
  // Strobes packed as {hsync, vsync, line_valid, frame_valid}, one word per stage
  logic [3:0] sync_1;
  logic [3:0] sync_2;
  logic [3:0] sync_3;
  logic [3:0] sync_4;

  function automatic logic [7:0] saturate(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] v;
    v = s >>> PREC;
    if (v[SW-1])
      saturate = 8'd0;
    else if (v > SW'(255))
      saturate = 8'd255;
    else
      saturate = v[7:0];
  endfunction

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      y      <= '0;
      cb     <= '0;
      cr     <= '0;
      y2     <= '0;
      pr     <= '0;
      pgb    <= '0;
      pgr    <= '0;
      pb     <= '0;
      sr     <= '0;
      sg     <= '0;
      sb     <= '0;
      oR     <= '0;
      oG     <= '0;
      oB     <= '0;
      sync_1 <= '0;
      sync_2 <= '0;
      sync_3 <= '0;
      sync_4 <= '0;
    end else begin
      // Chroma offset removal wraps modulo 512, which is exactly iC - 128 in 9-bit signed.
      y   <= iY;
      cb  <= 9'(iCb) - 9'd128;
      cr  <= 9'(iCr) - 9'd128;

      y2  <= PW'({y, {PREC{1'b0}}});
      pr  <= k_rcr * PW'(cr);
      pgb <= k_gcb * PW'(cb);
      pgr <= k_gcr * PW'(cr);
      pb  <= k_bcb * PW'(cb);

      sr  <= SW'(y2) + SW'(pr) + rnd;
      sg  <= SW'(y2) - SW'(pgb) - SW'(pgr) + rnd;
      sb  <= SW'(y2) + SW'(pb) + rnd;

      oR  <= saturate(sr);
      oG  <= saturate(sg);
      oB  <= saturate(sb);

      sync_1 <= {iHSync, iVSync, iLineValid, iFrameValid};
      sync_2 <= sync_1;
      sync_3 <= sync_2;
      sync_4 <= sync_3;
    end
  end

  assign oHSync      = sync_4[3];
  assign oVSync      = sync_4[2];
  assign oLineValid  = sync_4[1];
  assign oFrameValid = sync_4[0];

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Bench for ycbcr2rgb: integer reference model with a 4-deep expected queue,
// a per-cycle compare process, and literal checks for reset, latency and saturation corners.
module tb_ycbcr2rgb;

  logic       iClk;
  logic       iRst;
  logic [7:0] iY, iCb, iCr;
  logic       iHSync, iVSync, iLineValid, iFrameValid;
  logic [7:0] oR, oG, oB;
  logic       oHSync, oVSync, oLineValid, oFrameValid;

  ycbcr2rgb dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iY         (iY),
    .iCb        (iCb),
    .iCr        (iCr),
    .iHSync     (iHSync),
    .iVSync     (iVSync),
    .iLineValid (iLineValid),
    .iFrameValid(iFrameValid),
    .oR         (oR),
    .oG         (oG),
    .oB         (oB),
    .oHSync     (oHSync),
    .oVSync     (oVSync),
    .oLineValid (oLineValid),
    .oFrameValid(oFrameValid)
  );

  // ---------------- clock ----------------
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // ---------------- scoreboard state ----------------
  localparam int W = 28;  // {r, g, b, hsync, vsync, line_valid, frame_valid}
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  function automatic int clamp8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Fixed-point BT.601 inverse: coefficients scaled by 1024, round-half-up, floor divide.
  function automatic logic [W-1:0] model(input int y, input int cb, input int cr,
                                         input logic [3:0] s);
    int c_b, c_r, r, g, b;
    logic [7:0] r8, g8, b8;
    c_b = cb - 128;
    c_r = cr - 128;
    r = clamp8((y * 1024 + 1436 * c_r + 512) >>> 10);
    g = clamp8((y * 1024 - 352 * c_b - 731 * c_r + 512) >>> 10);
    b = clamp8((y * 1024 + 1815 * c_b + 512) >>> 10);
    r8 = r[7:0];
    g8 = g[7:0];
    b8 = b[7:0];
    return {r8, g8, b8, s};
  endfunction

  function automatic logic [W-1:0] dut_out();
    return {oR, oG, oB, oHSync, oVSync, oLineValid, oFrameValid};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got rgb=%0d/%0d/%0d sync=%b, want rgb=%0d/%0d/%0d sync=%b",
               name, $time, act[27:20], act[19:12], act[11:4], act[3:0],
               exp[27:20], exp[19:12], exp[11:4], exp[3:0]);
    end
  endtask

  // Record what each sampled pixel must become; only the newest four are in flight.
  always @(posedge iClk) begin
    if (!iRst) begin
      exp_q.push_back(model(iY, iCb, iCr, {iHSync, iVSync, iLineValid, iFrameValid}));
      if (exp_q.size() > 4) void'(exp_q.pop_front());
    end
  end

  always @(posedge iRst) exp_q.delete();

  // Every cycle: output must be the pixel sampled four edges ago, or zero if none has arrived.
  always @(negedge iClk) begin
    if (chk_en) begin
      if (exp_q.size() == 4) check("stream", dut_out(), exp_q[0]);
      else                   check("stream_empty", dut_out(), '0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                       input logic [3:0] s);
    iY = y;
    iCb = cb;
    iCr = cr;
    {iHSync, iVSync, iLineValid, iFrameValid} = s;
  endtask

  task automatic drive_random();
    drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
  endtask

  // Called just after a rising edge: apply one pixel, check it four edges later.
  task automatic apply_check(input string name, input logic [7:0] y, input logic [7:0] cb,
                             input logic [7:0] cr, input logic [7:0] er,
                             input logic [7:0] eg, input logic [7:0] eb);
    drive(y, cb, cr, 4'b0101);
    repeat (4) @(posedge iClk);
    #1 check(name, dut_out(), {er, eg, eb, 4'b0101});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    iRst = 1'b0;
    drive(8'd200, 8'd30, 8'd240, 4'b1111);

    // Model pinned to hand-computed values
    check("model_grey", model(128, 128, 128, 4'b0000), {8'd128, 8'd128, 8'd128, 4'b0000});
    check("model_possat", model(255, 255, 255, 4'b0000), {8'd255, 8'd121, 8'd255, 4'b0000});
    check("model_negsat", model(0, 128, 255, 4'b0000), {8'd178, 8'd0, 8'd0, 4'b0000});
    check("model_zero", model(0, 0, 0, 4'b0000), {8'd0, 8'd135, 8'd0, 4'b0000});

    // Asynchronous reset clears outputs immediately and keeps them clear
    #2 iRst = 1'b1;
    #1 check("reset_immediate", dut_out(), '0);
    chk_en = 1'b1;
    repeat (5) begin
      @(posedge iClk);
      #1 drive_random();
      check("reset_held", dut_out(), '0);
    end

    // First pixel after release appears exactly four edges later
    drive(8'd128, 8'd128, 8'd128, 4'b1111);
    @(negedge iClk);
    iRst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge iClk);
      #1 check("latency_early", dut_out(), '0);
    end
    @(posedge iClk);
    #1 check("latency_first", dut_out(), {8'd128, 8'd128, 8'd128, 4'b1111});

    // Corner pixels
    apply_check("grey",    8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128);
    apply_check("black",   8'd0,   8'd128, 8'd128, 8'd0,   8'd0,   8'd0);
    apply_check("white",   8'd255, 8'd128, 8'd128, 8'd255, 8'd255, 8'd255);
    apply_check("pos_sat", 8'd255, 8'd255, 8'd255, 8'd255, 8'd121, 8'd255);
    apply_check("neg_sat", 8'd0,   8'd128, 8'd255, 8'd178, 8'd0,   8'd0);
    apply_check("zero",    8'd0,   8'd0,   8'd0,   8'd0,   8'd135, 8'd0);

    // Random streaming with a one-pulse asynchronous reset in the middle
    for (int i = 0; i < 1000; i++) begin
      @(posedge iClk);
      #1 drive_random();
      if (i == 500) begin
        #1 iRst = 1'b1;
        #1 check("midframe_reset", dut_out(), '0);
        #1 iRst = 1'b0;
      end
    end

    repeat (6) @(posedge iClk);
    @(negedge iClk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
